led_flash_multi: RTL and testbench

Parametrised multi-channel LED driver, successor to the single-channel 1 Hz square-wave flasher. Each channel is independently configured at run time as OFF, ON, BLINK (programmable half-period), or PWM (programmable duty for brightness). After reset, every channel blinks at 1 Hz from a 27 MHz clock, so the block is a drop-in replacement for the old flasher. It sits between the board clock and the LED/IO pins and is configured by a simple write strobe from control logic.

---
 rtl/led_flash_multi.sv | 135 +++++++++++++
 tb/tb_led_flash_multi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_flash_multi.sv
// Multi-channel LED driver: each channel runs OFF, ON, BLINK (programmable half-period)
// or PWM (programmable duty). Out of reset every channel blinks at 1 Hz from 27 MHz.
module led_flash_multi #(
    parameter int unsigned          CHANNELS     = 4,
    parameter int unsigned          CNT_WIDTH    = 24,
    parameter int unsigned          PWM_WIDTH    = 8,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_HALF = 24'd13_499_999
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_ch,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_WIDTH-1:0] cfg_half_period,
    input  logic [PWM_WIDTH-1:0] cfg_duty,
    input  logic                 sync_pulse,
    output logic [CHANNELS-1:0]  IO_voltage,
    output logic [CHANNELS-1:0]  toggle_pulse
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    // Shared PWM timebase, free-running so all PWM channels stay phase-locked.
    logic [PWM_WIDTH-1:0] pwm_cnt_q;
    logic [PWM_WIDTH-1:0] pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the block order never matters.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Channel indices above CHANNELS-1 never match, so those writes drop silently.
        localparam logic [3:0] CH_IDX = 4'(g);

        mode_e                mode_q, mode_d;
        logic [CNT_WIDTH-1:0] half_q, half_d;
        logic [PWM_WIDTH-1:0] duty_q, duty_d;
        logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;
        logic                 out_q,  out_d;
        logic                 tog_q,  tog_d;
        logic                 cfg_hit;

        assign cfg_hit = cfg_we && (cfg_ch == CH_IDX);

        // NOTE: every _d gets a hold/default value first, so no path through
        // this block can leave a signal unassigned and infer a latch.
        always_comb begin
            mode_d = mode_q;
            half_d = half_q;
            duty_d = duty_q;
            cnt_d  = cnt_q;
            out_d  = out_q;
            tog_d  = 1'b0;

            if (cfg_hit) begin
                mode_d = mode_e'(cfg_mode);
                half_d = cfg_half_period;
                duty_d = cfg_duty;
                cnt_d  = '0;
                out_d  = 1'b0;
            end else if (sync_pulse && (mode_q == MODE_BLINK)) begin
                cnt_d = '0;
                out_d = 1'b0;
            end else begin
                case (mode_q)
                    MODE_OFF: begin
                        cnt_d = '0;
                        out_d = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d = '0;
                        out_d = 1'b1;
                    end
                    MODE_BLINK: begin
                        // >= rather than == so a half lowered below cnt still wraps.
                        if (cnt_q >= half_q) begin
                            cnt_d = '0;
                            out_d = ~out_q;
                            tog_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    MODE_PWM: begin
                        cnt_d = '0;
                        out_d = (pwm_cnt_q < duty_q);
                    end
                    default: begin
                        cnt_d = '0;
                        out_d = 1'b0;
                    end
                endcase
            end
        end

        // NOTE: the configuration registers are reset as well, because the
        // reset state itself (BLINK at DEFAULT_HALF) is the default behaviour.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                mode_q <= MODE_BLINK;
                half_q <= DEFAULT_HALF;
                duty_q <= '0;
                cnt_q  <= '0;
                out_q  <= 1'b0;
                tog_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                half_q <= half_d;
                duty_q <= duty_d;
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                tog_q  <= tog_d;
            end
        end

        assign IO_voltage[g]   = out_q;
        assign toggle_pulse[g] = tog_q;
    end

endmodule

// File: tb/tb_led_flash_multi.sv
// Directed and randomized bench for led_flash_multi, checked against a
// cycle-level reference model derived from the channel rules.
module tb_led_flash_multi;

    localparam int CH = 4;

    logic       Clock           = 1'b0;
    logic       Reset           = 1'b1;
    logic       cfg_we          = 1'b0;
    logic [3:0] cfg_ch          = 4'd0;
    logic [1:0] cfg_mode        = 2'd0;
    logic [7:0] cfg_half_period = 8'd0;
    logic [3:0] cfg_duty        = 4'd0;
    logic       sync_pulse      = 1'b0;
    logic [3:0] IO_voltage;
    logic [3:0] toggle_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: mode codes 0=OFF 1=ON 2=BLINK 3=PWM.
    int m_mode [CH];
    int m_half [CH];
    int m_duty [CH];
    int m_cnt  [CH];
    bit m_out  [CH];
    bit m_tog  [CH];
    int m_edges;

    led_flash_multi #(
        .CHANNELS     (4),
        .CNT_WIDTH    (8),
        .PWM_WIDTH    (4),
        .DEFAULT_HALF (8'd3)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .cfg_we          (cfg_we),
        .cfg_ch          (cfg_ch),
        .cfg_mode        (cfg_mode),
        .cfg_half_period (cfg_half_period),
        .cfg_duty        (cfg_duty),
        .sync_pulse      (sync_pulse),
        .IO_voltage      (IO_voltage),
        .toggle_pulse    (toggle_pulse)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The PWM phase is simply the number of edges since reset, modulo 16.
    function automatic void model_edge();
        int pwm_now;
        pwm_now = m_edges % 16;
        if (Reset) begin
            for (int i = 0; i < CH; i++) begin
                m_mode[i] = 2;
                m_half[i] = 3;
                m_duty[i] = 0;
                m_cnt[i]  = 0;
                m_out[i]  = 1'b0;
                m_tog[i]  = 1'b0;
            end
            m_edges = 0;
            return;
        end
        for (int i = 0; i < CH; i++) begin
            m_tog[i] = 1'b0;
            if (cfg_we && (int'(cfg_ch) == i)) begin
                m_mode[i] = int'(cfg_mode);
                m_half[i] = int'(cfg_half_period);
                m_duty[i] = int'(cfg_duty);
                m_cnt[i]  = 0;
                m_out[i]  = 1'b0;
            end else if (sync_pulse && m_mode[i] == 2) begin
                m_cnt[i] = 0;
                m_out[i] = 1'b0;
            end else if (m_mode[i] == 0) begin
                m_out[i] = 1'b0;
            end else if (m_mode[i] == 1) begin
                m_out[i] = 1'b1;
            end else if (m_mode[i] == 3) begin
                m_out[i] = (pwm_now < m_duty[i]);
            end else if (m_cnt[i] >= m_half[i]) begin
                m_cnt[i] = 0;
                m_out[i] = !m_out[i];
                m_tog[i] = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_edges = m_edges + 1;
    endfunction

    function automatic logic [3:0] exp_io();
        logic [3:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_out[i];
        return v;
    endfunction

    function automatic logic [3:0] exp_tog();
        logic [3:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_tog[i];
        return v;
    endfunction

    // One clock edge: advance the model with the inputs the DUT sampled, then compare.
    task automatic step();
        @(posedge Clock);
        model_edge();
        #1;
        check("io_vs_model", {28'd0, IO_voltage}, {28'd0, exp_io()});
        check("toggle_vs_model", {28'd0, toggle_pulse}, {28'd0, exp_tog()});
    endtask

    task automatic cfg_write(input int ch, input int mode, input int half, input int duty);
        cfg_we          = 1'b1;
        cfg_ch          = 4'(ch);
        cfg_mode        = 2'(mode);
        cfg_half_period = 8'(half);
        cfg_duty        = 4'(duty);
        step();
        cfg_we          = 1'b0;
    endtask

    task automatic count_high(input int ch, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            step();
            if (IO_voltage[ch]) n++;
        end
    endtask

    // Edges until channel ch pulses toggle; 0 means the budget ran out.
    task automatic wait_toggle(input int ch, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int k = 1; k <= budget && !seen; k++) begin
            step();
            if (toggle_pulse[ch] === 1'b1) begin
                seen = 1'b1;
                n = k;
            end
        end
    endtask

    initial begin
        int n;
        int n2;

        // Reset for two edges, then free-run in default BLINK half=3.
        step();
        step();
        check("reset_io", {28'd0, IO_voltage}, 32'h0);
        check("reset_tog", {28'd0, toggle_pulse}, 32'h0);
        Reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("default_hold", {28'd0, IO_voltage}, 32'h0);
        end
        step();
        check("default_first_toggle_io", {28'd0, IO_voltage}, 32'hF);
        check("default_first_toggle_pulse", {28'd0, toggle_pulse}, 32'hF);

        // ON and OFF channels; ch0 keeps its 8-cycle period.
        cfg_write(1, 1, 0, 0);
        check("on_write_edge", {31'd0, IO_voltage[1]}, 32'd0);
        step();
        check("on_next_edge", {31'd0, IO_voltage[1]}, 32'd1);
        cfg_write(2, 0, 0, 0);
        check("off_write_edge", {31'd0, IO_voltage[2]}, 32'd0);
        count_high(0, 16, n);
        check("ch0_period8_duty", n, 8);

        // PWM brightness on ch3.
        cfg_write(3, 3, 0, 4);
        count_high(3, 16, n);
        check("pwm_duty4", n, 4);
        cfg_write(3, 3, 0, 0);
        count_high(3, 16, n);
        check("pwm_duty0", n, 0);
        cfg_write(3, 3, 0, 15);
        count_high(3, 16, n);
        check("pwm_duty15", n, 15);

        // BLINK half=0 toggles every edge.
        cfg_write(0, 2, 0, 0);
        step();
        check("half0_io_a", {31'd0, IO_voltage[0]}, 32'd1);
        check("half0_tog_a", {31'd0, toggle_pulse[0]}, 32'd1);
        step();
        check("half0_io_b", {31'd0, IO_voltage[0]}, 32'd0);
        check("half0_tog_b", {31'd0, toggle_pulse[0]}, 32'd1);

        // A rewrite clears cnt, so half=100 first toggles 101 edges after its write.
        cfg_write(0, 2, 200, 0);
        repeat (150) step();
        cfg_write(0, 2, 100, 0);
        wait_toggle(0, 300, n);
        check("half100_first_toggle", n, 101);
        wait_toggle(0, 300, n);
        check("half100_steady", n, 101);

        // Sync aligns two offset BLINK channels.
        cfg_write(0, 2, 5, 0);
        step();
        step();
        cfg_write(1, 2, 5, 0);
        repeat (3) step();
        sync_pulse = 1'b1;
        step();
        sync_pulse = 1'b0;
        check("sync_clears", {30'd0, IO_voltage[1:0]}, 32'd0);
        wait_toggle(0, 20, n);
        check("sync_ch0_after6", n, 6);
        check("sync_ch1_together", {31'd0, toggle_pulse[1]}, 32'd1);

        // Sync plus a write to ch0 on the same edge.
        sync_pulse = 1'b1;
        cfg_write(0, 2, 2, 0);
        sync_pulse = 1'b0;
        check("sync_write_tog", {30'd0, toggle_pulse[1:0]}, 32'd0);
        check("sync_write_io", {30'd0, IO_voltage[1:0]}, 32'd0);
        wait_toggle(0, 20, n);
        check("sync_write_ch0", n, 3);
        wait_toggle(1, 20, n2);
        check("sync_write_ch1", n + n2, 6);

        // Reset wins over a simultaneous write, then an out-of-range write is ignored.
        cfg_write(2, 3, 0, 8);
        repeat (5) step();
        Reset    = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 4'd2;
        cfg_mode = 2'd1;
        step();
        Reset  = 1'b0;
        cfg_we = 1'b0;
        check("reset_write_io", {28'd0, IO_voltage}, 32'h0);
        wait_toggle(2, 20, n);
        check("reset_write_ch2_blink", n, 4);
        check("reset_write_all_toggle", {28'd0, IO_voltage}, 32'hF);
        cfg_write(7, 1, 0, 15);
        wait_toggle(0, 20, n);
        check("bad_ch_ignored_time", n, 3);
        check("bad_ch_ignored_io", {28'd0, IO_voltage}, 32'h0);

        // Randomized traffic against the model.
        repeat (600) begin
            Reset           = ($urandom_range(0, 149) == 0);
            cfg_we          = ($urandom_range(0, 5) == 0);
            cfg_ch          = 4'($urandom_range(0, 7));
            cfg_mode        = 2'($urandom_range(0, 3));
            cfg_half_period = 8'($urandom_range(0, 6));
            cfg_duty        = 4'($urandom_range(0, 15));
            sync_pulse      = ($urandom_range(0, 11) == 0);
            step();
        end
        Reset      = 1'b0;
        cfg_we     = 1'b0;
        sync_pulse = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
